// File: rtl/pc_unit.sv
// Program counter with fixed-priority redirect selection (JR > J > taken branch > sequential).
// Optional single branch delay slot is compiled in when BRANCH_DELAY_SLOT_EN is defined.
module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_eq,
   input  logic        branch_ne,
   input  logic        alu_zero,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] rs_value,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        taken,
   output logic        addr_err
);

   logic [31:0] pc_r;
   logic        taken_r;
   logic        addr_err_r;

   logic [31:0] pc_plus4_s;
   logic [31:0] branch_target_s;
   logic [31:0] jump_target_s;
   logic        jr_misaligned_s;
   logic        branch_taken_s;
   logic        redirect_s;
   logic [31:0] redirect_target_s;

   // Values the sequencing logic below must produce every cycle
   logic [31:0] pc_next_s;
   logic        accept_s;
   logic        eval_s;

   assign pc_plus4_s      = pc_r + 32'd4;
   assign branch_target_s = pc_plus4_s + {{14{imm16[15]}}, imm16, 2'b00};
   assign jump_target_s   = {pc_plus4_s[31:28], target26, 2'b00};

   assign pc       = pc_r;
   assign pc_plus4 = pc_plus4_s;
   assign taken    = taken_r;
   assign addr_err = addr_err_r;

   // Redirect request decode and priority selection
   always_comb begin
      jr_misaligned_s   = jump_reg && (rs_value[1:0] != 2'b00);
      branch_taken_s    = (branch_eq && alu_zero) || (branch_ne && !alu_zero);
      redirect_s        = 1'b0;
      redirect_target_s = pc_plus4_s;
      if (jump_reg) begin
         // A misaligned JR does not fall through to lower-priority requests
         if (!jr_misaligned_s) begin
            redirect_s        = 1'b1;
            redirect_target_s = rs_value;
         end else begin
            redirect_s        = 1'b0;
            redirect_target_s = pc_plus4_s;
         end
      end else if (jump) begin
         redirect_s        = 1'b1;
         redirect_target_s = jump_target_s;
      end else if (branch_taken_s) begin
         redirect_s        = 1'b1;
         redirect_target_s = branch_target_s;
      end else begin
         redirect_s        = 1'b0;
         redirect_target_s = pc_plus4_s;
      end
   end

`ifdef BRANCH_DELAY_SLOT_EN
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SLOT = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [31:0] target_r;
   logic        target_load_s;

   // FSM state and latched delay-slot target
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         target_r <= 32'h0000_0000;
      end else begin
         state_r <= state_next_s;
         if (target_load_s) begin
            target_r <= redirect_target_s;
         end else begin
            target_r <= target_r;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!stall && redirect_s) begin
               state_next_s = SLOT;
            end else begin
               state_next_s = IDLE;
            end
         end
         SLOT: begin
            if (!stall) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = SLOT;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Output logic: delay slot executes pc_plus4 before the latched target
   always_comb begin
      pc_next_s     = pc_r;
      accept_s      = 1'b0;
      eval_s        = 1'b0;
      target_load_s = 1'b0;
      case (state_r)
         IDLE: begin
            eval_s        = !stall;
            accept_s      = !stall && redirect_s;
            target_load_s = accept_s;
            if (!stall) begin
               pc_next_s = pc_plus4_s;
            end else begin
               pc_next_s = pc_r;
            end
         end
         SLOT: begin
            if (!stall) begin
               pc_next_s = target_r;
            end else begin
               pc_next_s = pc_r;
            end
         end
         default: pc_next_s = pc_r;
      endcase
   end
`else
   // Direct redirect: selected next PC lands one cycle after the request
   always_comb begin
      eval_s   = !stall;
      accept_s = !stall && redirect_s;
      if (stall) begin
         pc_next_s = pc_r;
      end else if (redirect_s) begin
         pc_next_s = redirect_target_s;
      end else begin
         pc_next_s = pc_plus4_s;
      end
   end
`endif

   // PC, taken pulse and sticky misalignment flag
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r       <= RESET_PC;
         taken_r    <= 1'b0;
         addr_err_r <= 1'b0;
      end else begin
         pc_r       <= pc_next_s;
         taken_r    <= accept_s;
         addr_err_r <= addr_err_r | (eval_s & jr_misaligned_s);
      end
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall  input  1  hold PC and all state this cycle.
REQ-005 SHALL have port: branch_eq  input  1  BEQ in decode; taken when alu_zero=1.
REQ-006 SHALL have port: branch_ne  input  1  BNE in decode; taken when alu_zero=0.
REQ-007 SHALL have port: alu_zero  input  1  zero flag from the ALU 32-bit OR-reduce/NOR tree.
REQ-008 SHALL have port: jump  input  1  J/JAL in decode.
REQ-009 SHALL have port: jump_reg  input  1  JR/JALR in decode.
REQ-010 SHALL have port: imm16  input  16  branch offset in words, signed.
REQ-011 SHALL have port: target26  input  26  jump word index.
REQ-012 SHALL have port: rs_value  input  32  JR target.
REQ-013 SHALL have port: pc  output  32  current fetch address, registered.
REQ-014 SHALL have port: pc_plus4  output  32  pc + 4, combinational.
REQ-015 SHALL have port: taken  output  1  registered pulse: redirect accepted in the previous cycle.
REQ-016 SHALL have port: addr_err  output  1  sticky flag: misaligned JR target seen.

Function
REQ-017 SHALL compute pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-018 SHALL form branch target = pc_plus4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-019 SHALL form jump target = {pc_plus4[31:28], target26, 2'b00}.
REQ-020 SHALL use rs_value as the JR target.
REQ-021 SHALL select redirect by fixed priority when several requests are asserted: jump_reg > jump > taken branch_eq/branch_ne > sequential pc_plus4.
REQ-022 SHALL treat a JR with rs_value[1:0] != 0 as no redirect (sequential pc_plus4) and set addr_err, which holds at 1 until reset.
REQ-023 SHALL, when stall=1, hold pc, the FSM state, pending target and taken=0, and ignore all redirect inputs in that cycle.
REQ-024 SHALL, when stall=0 with no pending redirect, load the selected next PC on the clock edge; latency is one cycle from request to new pc.
REQ-025 SHALL set taken=1 for exactly one cycle after a non-stalled cycle that accepted a redirect, else 0.
REQ-026 SHALL ignore a redirect request that arrives while a delay-slot redirect is pending (see REQ-031).

Reset
REQ-027 SHALL, when reset=1 at a clock edge, load pc=RESET_PC, taken=0, addr_err=0, FSM=IDLE and clear any pending target, regardless of stall or redirect inputs.
REQ-028 SHALL discard any redirect that is in flight when reset is asserted mid-operation.

Configuration
REQ-029 SHALL compile in a branch delay slot when macro BRANCH_DELAY_SLOT_EN is defined.
REQ-030 SHALL, without BRANCH_DELAY_SLOT_EN, apply every redirect directly per REQ-024, with no FSM and no target register.
REQ-031 SHALL, with BRANCH_DELAY_SLOT_EN, use FSM IDLE/SLOT:
- IDLE + accepted redirect -> latch target, pc <= pc_plus4, go to SLOT.
- SLOT + !stall -> pc <= latched target, go to IDLE.
- stall holds the state.
- taken pulses in the cycle after the redirect is accepted, i.e. when the latch occurs.

Verification
REQ-032 SHALL verify reset: reset=1 with RESET_PC=32'h0040_0000 and jump=1 -> pc=0x0040_0000, taken=0, addr_err=0.
REQ-033 SHALL verify branch: pc=0x100, branch_eq=1, alu_zero=1, imm16=16'hFFFE -> pc=0x0FC, taken=1; alu_zero=0 instead -> pc=0x104, taken=0.
REQ-034 SHALL verify priority and jump: pc=0x1000_0000, jump=1, jump_reg=1, rs_value=0x2000 -> pc=0x2000; with jump_reg=0, target26=0x10 -> pc=0x1000_0040.
REQ-035 SHALL verify JR misalignment: jump_reg=1, rs_value=0x2002 at pc=0x200 -> pc=0x204, addr_err=1 and still 1 ten cycles later.
REQ-036 SHALL verify stall and wrap: stall=1 for 3 cycles with branch_ne=1 -> pc unchanged, taken=0; pc=0xFFFF_FFFC with no request -> pc=0x0000_0000.
REQ-037 SHALL verify delay slot (BRANCH_DELAY_SLOT_EN): pc=0x100, jump target 0x400 -> pc sequence 0x104 then 0x400; reset asserted in SLOT -> pc=RESET_PC, target discarded.
